offset_filter: RTL and testbench

OFFSET_FILTER -- requirements
Module: offset_filter

---
 rtl/offset_filter.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_offset_filter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/offset_filter.sv
// -----------------------------------------------------------------------------
// offset_filter
//
// Purpose:
//   Streams per-channel duty/phase values through a fixed 3-stage pipeline and
//   adds a signed per-channel offset to each of them. The corrected duty is
//   clamped to [0, T]. The corrected phase either wraps modulo T or saturates
//   to [0, T-1]. T is the channel period. The module counts how many channels
//   per frame needed a duty clamp.
//
// Ports:
//   CLK           system clock (single domain)
//   RST           synchronous active-high reset
//   FILTER_EN     1 = apply offsets, 0 = pass raw values through
//   PHASE_MODE    0 = phase wraps modulo T, 1 = phase saturates to [0, T-1]
//   FILTER_DUTY   DEPTH packed signed (WIDTH+1)-bit duty offsets, channel 0 at LSB
//   FILTER_PHASE  DEPTH packed signed (WIDTH+1)-bit phase offsets, channel 0 at LSB
//   CYCLE         DEPTH packed WIDTH-bit periods T, channel 0 at LSB
//   DIN_VALID     one DUTY/PHASE element present this cycle
//   DIN_FIRST     with DIN_VALID: element is channel 0 of a frame
//   DUTY, PHASE   raw channel values
//   DUTY_F        filtered duty (holds between valid outputs)
//   PHASE_F       filtered phase (holds between valid outputs)
//   DOUT_VALID    DUTY_F/PHASE_F carry a new element this cycle
//   DOUT_IDX      channel index of the current output
//   DOUT_LAST     output belongs to channel DEPTH-1
//   CLAMP_CNT     number of duty-clamped channels in the last completed frame
// -----------------------------------------------------------------------------
module offset_filter #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         FILTER_EN,
  input  logic                         PHASE_MODE,
  input  logic [DEPTH*(WIDTH+1)-1:0]   FILTER_DUTY,
  input  logic [DEPTH*(WIDTH+1)-1:0]   FILTER_PHASE,
  input  logic [DEPTH*WIDTH-1:0]       CYCLE,
  input  logic                         DIN_VALID,
  input  logic                         DIN_FIRST,
  input  logic [WIDTH-1:0]             DUTY,
  input  logic [WIDTH-1:0]             PHASE,
  output logic [WIDTH-1:0]             DUTY_F,
  output logic [WIDTH-1:0]             PHASE_F,
  output logic                         DOUT_VALID,
  output logic [IW-1:0]                DOUT_IDX,
  output logic                         DOUT_LAST,
  output logic [CW-1:0]                CLAMP_CNT
);

  // Sum width: one bit above the unsigned operand plus a sign bit.
  localparam int SW = WIDTH + 2;

  // ---------------------------------------------------------------------------
  // Input index tracking
  // ---------------------------------------------------------------------------
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic [IW-1:0]    idx_sel_s;
  logic             idx_last_s;
  logic [WIDTH:0]   fd_sel_s;
  logic [WIDTH:0]   fp_sel_s;
  logic [WIDTH-1:0] t_sel_s;

  // Channel index of the incoming element and the counter's next value.
  always_comb begin
    if (DIN_FIRST) begin
      idx_sel_s = {IW{1'b0}};
    end else begin
      idx_sel_s = idx_q;
    end
    idx_last_s = (idx_sel_s == IW'(DEPTH - 1));
    if (!DIN_VALID) begin
      idx_d = idx_q;
    end else if (idx_last_s) begin
      idx_d = {IW{1'b0}};
    end else begin
      idx_d = idx_sel_s + IW'(1);
    end
  end

  // Table lookup for the incoming element's channel.
  always_comb begin
    fd_sel_s = FILTER_DUTY[idx_sel_s * (WIDTH + 1) +: (WIDTH + 1)];
    fp_sel_s = FILTER_PHASE[idx_sel_s * (WIDTH + 1) +: (WIDTH + 1)];
    t_sel_s  = CYCLE[idx_sel_s * WIDTH +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture element, index, mode bits and table entries
  // ---------------------------------------------------------------------------
  logic             s1_valid_q;
  logic             s1_first_q;
  logic             s1_last_q;
  logic [IW-1:0]    s1_idx_q;
  logic [WIDTH-1:0] s1_duty_q;
  logic [WIDTH-1:0] s1_phase_q;
  logic             s1_en_q;
  logic             s1_mode_q;
  logic [WIDTH:0]   s1_fd_q;
  logic [WIDTH:0]   s1_fp_q;
  logic [WIDTH-1:0] s1_t_q;

  // Stage 1 registers and the input index counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q      <= {IW{1'b0}};
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= {IW{1'b0}};
      s1_duty_q  <= {WIDTH{1'b0}};
      s1_phase_q <= {WIDTH{1'b0}};
      s1_en_q    <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_fd_q    <= {(WIDTH+1){1'b0}};
      s1_fp_q    <= {(WIDTH+1){1'b0}};
      s1_t_q     <= {WIDTH{1'b0}};
    end else begin
      idx_q      <= idx_d;
      s1_valid_q <= DIN_VALID;
      s1_first_q <= DIN_VALID & DIN_FIRST;
      s1_last_q  <= idx_last_s;
      s1_idx_q   <= idx_sel_s;
      s1_duty_q  <= DUTY;
      s1_phase_q <= PHASE;
      s1_en_q    <= FILTER_EN;
      s1_mode_q  <= PHASE_MODE;
      s1_fd_q    <= fd_sel_s;
      s1_fp_q    <= fp_sel_s;
      s1_t_q     <= t_sel_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: signed sums
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] sd_s;
  logic signed [SW-1:0] sp_s;

  // Raw value is zero-extended, offset is sign-extended, both to SW bits.
  always_comb begin
    sd_s = $signed({2'b00, s1_duty_q})  + $signed({s1_fd_q[WIDTH], s1_fd_q});
    sp_s = $signed({2'b00, s1_phase_q}) + $signed({s1_fp_q[WIDTH], s1_fp_q});
  end

  logic                 s2_valid_q;
  logic                 s2_first_q;
  logic                 s2_last_q;
  logic [IW-1:0]        s2_idx_q;
  logic [WIDTH-1:0]     s2_duty_q;
  logic [WIDTH-1:0]     s2_phase_q;
  logic                 s2_en_q;
  logic                 s2_mode_q;
  logic [WIDTH-1:0]     s2_t_q;
  logic signed [SW-1:0] s2_sd_q;
  logic signed [SW-1:0] s2_sp_q;

  // Stage 2 registers: sums plus everything the limiter needs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_idx_q   <= {IW{1'b0}};
      s2_duty_q  <= {WIDTH{1'b0}};
      s2_phase_q <= {WIDTH{1'b0}};
      s2_en_q    <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_t_q     <= {WIDTH{1'b0}};
      s2_sd_q    <= {SW{1'b0}};
      s2_sp_q    <= {SW{1'b0}};
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_idx_q   <= s1_idx_q;
      s2_duty_q  <= s1_duty_q;
      s2_phase_q <= s1_phase_q;
      s2_en_q    <= s1_en_q;
      s2_mode_q  <= s1_mode_q;
      s2_t_q     <= s1_t_q;
      s2_sd_q    <= sd_s;
      s2_sp_q    <= sp_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: limiting, clamp accounting, output registers
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] t_ext_s;
  logic [WIDTH-1:0]     duty_res_s;
  logic [WIDTH-1:0]     phase_res_s;
  logic                 clamp_ev_s;

  // Duty clamp and phase wrap/saturate. The single-fold wrap is done in WIDTH
  // bits: the folded result is known to fit, so modular arithmetic on the low
  // bits gives the exact value.
  always_comb begin
    t_ext_s     = $signed({2'b00, s2_t_q});
    duty_res_s  = s2_duty_q;
    phase_res_s = s2_phase_q;
    clamp_ev_s  = 1'b0;
    if (!s2_en_q) begin
      duty_res_s  = s2_duty_q;
      phase_res_s = s2_phase_q;
    end else if (s2_t_q == {WIDTH{1'b0}}) begin
      duty_res_s  = {WIDTH{1'b0}};
      phase_res_s = {WIDTH{1'b0}};
    end else begin
      if (s2_sd_q > t_ext_s) begin
        duty_res_s = s2_t_q;
        clamp_ev_s = s2_valid_q;
      end else if (s2_sd_q[SW-1]) begin
        duty_res_s = {WIDTH{1'b0}};
        clamp_ev_s = s2_valid_q;
      end else begin
        duty_res_s = s2_sd_q[WIDTH-1:0];
      end

      if (s2_mode_q) begin
        if (s2_sp_q >= t_ext_s) begin
          phase_res_s = s2_t_q - WIDTH'(1);
        end else if (s2_sp_q[SW-1]) begin
          phase_res_s = {WIDTH{1'b0}};
        end else begin
          phase_res_s = s2_sp_q[WIDTH-1:0];
        end
      end else begin
        if (s2_sp_q >= t_ext_s) begin
          phase_res_s = s2_sp_q[WIDTH-1:0] - s2_t_q;
        end else if (s2_sp_q[SW-1]) begin
          phase_res_s = s2_sp_q[WIDTH-1:0] + s2_t_q;
        end else begin
          phase_res_s = s2_sp_q[WIDTH-1:0];
        end
      end
    end
  end

  logic [CW-1:0] acc_q;
  logic [CW-1:0] acc_base_s;
  logic [CW-1:0] acc_sum_s;

  // A frame start restarts the count; the accumulator saturates at DEPTH.
  always_comb begin
    if (s2_first_q) begin
      acc_base_s = {CW{1'b0}};
    end else begin
      acc_base_s = acc_q;
    end
    if (clamp_ev_s && (acc_base_s != CW'(DEPTH))) begin
      acc_sum_s = acc_base_s + CW'(1);
    end else begin
      acc_sum_s = acc_base_s;
    end
  end

  logic [WIDTH-1:0] duty_f_q;
  logic [WIDTH-1:0] phase_f_q;
  logic             dout_valid_q;
  logic [IW-1:0]    dout_idx_q;
  logic             dout_last_q;
  logic [CW-1:0]    clamp_cnt_q;

  // Output registers and the clamp accumulator.
  always_ff @(posedge CLK) begin
    if (RST) begin
      duty_f_q     <= {WIDTH{1'b0}};
      phase_f_q    <= {WIDTH{1'b0}};
      dout_valid_q <= 1'b0;
      dout_idx_q   <= {IW{1'b0}};
      dout_last_q  <= 1'b0;
      clamp_cnt_q  <= {CW{1'b0}};
      acc_q        <= {CW{1'b0}};
    end else begin
      dout_valid_q <= s2_valid_q;
      dout_last_q  <= s2_valid_q & s2_last_q;
      if (s2_valid_q) begin
        duty_f_q   <= duty_res_s;
        phase_f_q  <= phase_res_s;
        dout_idx_q <= s2_idx_q;
        if (s2_last_q) begin
          clamp_cnt_q <= acc_sum_s;
          acc_q       <= {CW{1'b0}};
        end else begin
          acc_q <= acc_sum_s;
        end
      end
    end
  end

  assign DUTY_F     = duty_f_q;
  assign PHASE_F    = phase_f_q;
  assign DOUT_VALID = dout_valid_q;
  assign DOUT_IDX   = dout_idx_q;
  assign DOUT_LAST  = dout_last_q;
  assign CLAMP_CNT  = clamp_cnt_q;

endmodule

// File: tb/tb_offset_filter.sv
// -----------------------------------------------------------------------------
// tb_offset_filter
//
// Directed-vector bench for offset_filter. Stimulus pushes the hand-computed
// expected output of every element into a queue; a negedge monitor pops and
// compares whenever DOUT_VALID is high.
// -----------------------------------------------------------------------------
module tb_offset_filter;

  localparam int WIDTH = 13;
  localparam int DEPTH = 249;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic                       CLK = 1'b0;
  logic                       RST = 1'b1;
  logic                       FILTER_EN = 1'b0;
  logic                       PHASE_MODE = 1'b0;
  logic [DEPTH*(WIDTH+1)-1:0] FILTER_DUTY;
  logic [DEPTH*(WIDTH+1)-1:0] FILTER_PHASE;
  logic [DEPTH*WIDTH-1:0]     CYCLE;
  logic                       DIN_VALID = 1'b0;
  logic                       DIN_FIRST = 1'b0;
  logic [WIDTH-1:0]           DUTY = '0;
  logic [WIDTH-1:0]           PHASE = '0;
  logic [WIDTH-1:0]           DUTY_F;
  logic [WIDTH-1:0]           PHASE_F;
  logic                       DOUT_VALID;
  logic [IW-1:0]              DOUT_IDX;
  logic                       DOUT_LAST;
  logic [CW-1:0]              CLAMP_CNT;

  offset_filter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .FILTER_EN(FILTER_EN), .PHASE_MODE(PHASE_MODE),
    .FILTER_DUTY(FILTER_DUTY), .FILTER_PHASE(FILTER_PHASE), .CYCLE(CYCLE),
    .DIN_VALID(DIN_VALID), .DIN_FIRST(DIN_FIRST), .DUTY(DUTY), .PHASE(PHASE),
    .DUTY_F(DUTY_F), .PHASE_F(PHASE_F), .DOUT_VALID(DOUT_VALID),
    .DOUT_IDX(DOUT_IDX), .DOUT_LAST(DOUT_LAST), .CLAMP_CNT(CLAMP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int duty;
    int phase;
    int idx;
    int last;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   hold_chk = 1'b0;
  int   last_d = 0;
  int   last_p = 0;
  exp_t mon_e;

  // Directed vectors for channels 0..6 (filter enabled), hand-computed.
  // ch0 T=4000 fd=+500 fp=+300 : 1000->1500, 3900->200 (wrap)
  // ch1 T=4000 fd=+400 fp=-300 : 3800->4000 (clamp), 100->3800 (wrap)
  // ch2 T=4000 fd=-200 fp=-300 : 100->0 (clamp),     100->0 (saturate)
  // ch3 T=4000 fd=0    fp=+300 : 50->50,             3900->3999 (saturate)
  // ch4 T=0    fd=+100 fp=+100 : 77->0,              88->0
  // ch5 T=4000 fd=+100 fp=+50  : 3900->4000 (sd==T, no clamp), 3950->0 (wrap)
  // ch6 T=1000 fd=-100 fp=+10  : 100->0 (sd==0, no clamp), 989->999 (saturate mode)
  int vd[7] = '{1000, 3800, 100,   50, 77, 3900, 100};
  int vp[7] = '{3900,  100, 100, 3900, 88, 3950, 989};
  int vm[7] = '{   0,    0,   1,    1,  0,    0,   1};
  int ed[7] = '{1500, 4000,   0,   50,  0, 4000,   0};
  int ep[7] = '{ 200, 3800,   0, 3999,  0,    0, 999};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    total_cnt++;
    if (act == exp_v) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic set_ch(input int ch, input int t, input int fdo, input int fpo);
    CYCLE[ch*WIDTH +: WIDTH]               = t[WIDTH-1:0];
    FILTER_DUTY[ch*(WIDTH+1) +: WIDTH+1]   = fdo[WIDTH:0];
    FILTER_PHASE[ch*(WIDTH+1) +: WIDTH+1]  = fpo[WIDTH:0];
  endtask

  task automatic send(input int ch, input bit first, input bit en);
    exp_t e;
    int d, p, m;
    if (ch < 7) begin
      d = vd[ch]; p = vp[ch]; m = vm[ch];
    end else begin
      d = ch * 10; p = ch * 13; m = 0;
    end
    @(negedge CLK);
    RST        = 1'b0;
    DIN_VALID  = 1'b1;
    DIN_FIRST  = first;
    FILTER_EN  = en;
    PHASE_MODE = m[0];
    DUTY       = d[WIDTH-1:0];
    PHASE      = p[WIDTH-1:0];
    e.duty  = (en && ch < 7) ? ed[ch] : d;
    e.phase = (en && ch < 7) ? ep[ch] : p;
    e.idx   = ch;
    e.last  = (ch == DEPTH - 1) ? 1 : 0;
    e.cyc   = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge CLK);
    DIN_VALID = 1'b0;
    DIN_FIRST = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while (sb.size() != 0 && n < 12) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  always @(negedge CLK) begin
    if (DOUT_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got idx %0d, expected no output", DOUT_IDX);
      end else begin
        mon_e = sb.pop_front();
        chk("out_cycle", cyc, mon_e.cyc);
        chk("duty_f", int'(DUTY_F), mon_e.duty);
        chk("phase_f", int'(PHASE_F), mon_e.phase);
        chk("dout_idx", int'(DOUT_IDX), mon_e.idx);
        chk("dout_last", int'(DOUT_LAST), mon_e.last);
        last_d = mon_e.duty;
        last_p = mon_e.phase;
      end
    end else if (hold_chk) begin
      chk("hold_duty", int'(DUTY_F), last_d);
      chk("hold_phase", int'(PHASE_F), last_p);
      chk("idle_last", int'(DOUT_LAST), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    FILTER_DUTY  = '0;
    FILTER_PHASE = '0;
    CYCLE        = '0;
    for (int i = 0; i < DEPTH; i++) set_ch(i, 4000, 0, 0);
    set_ch(0, 4000,  500,  300);
    set_ch(1, 4000,  400, -300);
    set_ch(2, 4000, -200, -300);
    set_ch(3, 4000,    0,  300);
    set_ch(4,    0,  100,  100);
    set_ch(5, 4000,  100,   50);
    set_ch(6, 1000, -100,   10);

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_valid", int'(DOUT_VALID), 0);
    chk("rst_last", int'(DOUT_LAST), 0);
    chk("rst_idx", int'(DOUT_IDX), 0);
    chk("rst_duty", int'(DUTY_F), 0);
    chk("rst_phase", int'(PHASE_F), 0);
    chk("rst_clamp", int'(CLAMP_CNT), 0);

    // Frame A: filter on, full back-to-back frame, two duty clamps.
    for (int ch = 0; ch < DEPTH; ch++) send(ch, ch == 0, 1'b1);
    drain();
    chk("clamp_cnt_a", int'(CLAMP_CNT), 2);

    // Frame B: bypass with non-zero offsets, occasional bubbles.
    set_ch(4, 4000, 100, 100);
    hold_chk = 1'b1;
    for (int ch = 0; ch < DEPTH; ch++) begin
      send(ch, ch == 0, 1'b0);
      if (ch % 50 == 49) idle();
    end
    drain();
    hold_chk = 1'b0;
    chk("clamp_cnt_b", int'(CLAMP_CNT), 0);

    // Frame C: restart mid-frame; clamps from the aborted part are dropped.
    set_ch(4, 0, 100, 100);
    send(0, 1'b1, 1'b1);
    send(1, 1'b0, 1'b1);
    send(2, 1'b0, 1'b1);
    for (int ch = 0; ch < DEPTH; ch++) send(ch, ch == 0, 1'b1);
    drain();
    chk("clamp_cnt_c", int'(CLAMP_CNT), 2);

    // Reset at channel 100, then an element without DIN_FIRST is channel 0.
    for (int ch = 0; ch < 100; ch++) send(ch, ch == 0, 1'b1);
    @(negedge CLK);
    RST       = 1'b1;
    DIN_VALID = 1'b0;
    DIN_FIRST = 1'b0;
    @(negedge CLK);
    chk("midrst_valid", int'(DOUT_VALID), 0);
    chk("midrst_last", int'(DOUT_LAST), 0);
    chk("midrst_idx", int'(DOUT_IDX), 0);
    chk("midrst_duty", int'(DUTY_F), 0);
    chk("midrst_clamp", int'(CLAMP_CNT), 0);
    sb.delete();
    send(0, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
